// File: rtl/afu_mmio_pkg.sv
// Shared definitions for the MMIO-fronted FIFO controller:
// register map offsets, CTRL bit positions and the STATUS word layout.
package afu_mmio_pkg;

    typedef logic [8:0] t_mmio_tid;

    localparam logic [15:0] REG_DATA   = 16'h0000;
    localparam logic [15:0] REG_STATUS = 16'h0002;
    localparam logic [15:0] REG_CTRL   = 16'h0004;
    localparam logic [15:0] REG_THRESH = 16'h0006;

    localparam int unsigned CTRL_FLUSH      = 0;
    localparam int unsigned CTRL_CLR_STICKY = 1;

    typedef struct packed {
        logic [31:0] rsvd_hi;
        logic [15:0] level;
        logic [11:0] rsvd_lo;
        logic        underflow;
        logic        overflow;
        logic        full;
        logic        empty;
    } t_fifo_status;

    typedef enum logic [1:0] {
        SelData,
        SelStatus,
        SelCtrl,
        SelThresh
    } t_reg_sel;

    function automatic t_fifo_status pack_status(
        input logic [15:0] level,
        input logic        underflow,
        input logic        overflow,
        input logic        full,
        input logic        empty
    );
        t_fifo_status s;
        s           = '0;
        s.level     = level;
        s.underflow = underflow;
        s.overflow  = overflow;
        s.full      = full;
        s.empty     = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_fifo_ram.sv
// FIFO storage: simple dual-port RAM, synchronous write, registered read.
// A same-address read and write in one cycle returns the old contents.
module mmio_fifo_ram #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-facing FIFO controller: DATA pushes/pops, STATUS/CTRL/THRESH registers,
// two-cycle pipelined read responses toward the c2 mux.
module mmio_fifo_ctrl
    import afu_mmio_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned DATA_W    = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mmio_wr_valid,
    input  logic                   i_mmio_rd_valid,
    input  logic [15:0]            i_mmio_addr,
    input  t_mmio_tid              i_mmio_tid,
    input  logic [DATA_W-1:0]      i_mmio_wr_data,
    output logic                   o_rd_rsp_valid,
    output t_mmio_tid              o_rd_rsp_tid,
    output logic [DATA_W-1:0]      o_rd_rsp_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [15:0] ADDR_DATA   = BASE_ADDR + REG_DATA;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + REG_CTRL;
    localparam logic [15:0] ADDR_THRESH = BASE_ADDR + REG_THRESH;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_level;
    logic              r_overflow;
    logic              r_underflow;
    logic [CW-1:0]     r_thresh;
    logic              r_almost_full;

    logic              r_s1_valid;
    t_mmio_tid         r_s1_tid;
    t_reg_sel          r_s1_sel;
    logic              r_s1_pop;
    t_fifo_status      r_s1_status;
    logic [CW-1:0]     r_s1_thresh;

    logic              r_rsp_valid;
    t_mmio_tid         r_rsp_tid;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_wr_data;
    logic              w_wr_ctrl;
    logic              w_wr_thresh;
    logic              w_rd_hit;
    logic              w_rd_data;
    t_reg_sel          w_rd_sel;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_clr_sticky;

    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [CW-1:0]     w_level_nxt;
    logic              w_overflow_nxt;
    logic              w_underflow_nxt;
    logic [CW-1:0]     w_thresh_nxt;

    t_fifo_status      w_status;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_rsp_data;

    // Address decode
    assign w_wr_data   = i_mmio_wr_valid && (i_mmio_addr == ADDR_DATA);
    assign w_wr_ctrl   = i_mmio_wr_valid && (i_mmio_addr == ADDR_CTRL);
    assign w_wr_thresh = i_mmio_wr_valid && (i_mmio_addr == ADDR_THRESH);

    always_comb begin
        w_rd_hit = i_mmio_rd_valid;
        w_rd_sel = SelData;
        case (i_mmio_addr)
            ADDR_DATA:   w_rd_sel = SelData;
            ADDR_STATUS: w_rd_sel = SelStatus;
            ADDR_CTRL:   w_rd_sel = SelCtrl;
            ADDR_THRESH: w_rd_sel = SelThresh;
            default:     w_rd_hit = 1'b0;
        endcase
    end

    assign w_rd_data = w_rd_hit && (w_rd_sel == SelData);

    assign w_full  = (r_level == CW'(DEPTH));
    assign w_empty = (r_level == '0);

    // The pop is judged on pre-push occupancy; a full FIFO accepts a push only alongside a pop.
    assign w_pop        = w_rd_data && !w_empty;
    assign w_push       = w_wr_data && (!w_full || w_pop);
    assign w_flush      = w_wr_ctrl && i_mmio_wr_data[CTRL_FLUSH];
    assign w_clr_sticky = w_wr_ctrl && i_mmio_wr_data[CTRL_CLR_STICKY];

    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_level_nxt     = r_level;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_thresh_nxt    = r_thresh;

        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        end
        unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + CW'(1);
            2'b01:   w_level_nxt = r_level - CW'(1);
            default: w_level_nxt = r_level;
        endcase

        if (w_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_level_nxt  = '0;
        end

        // A fresh overflow/underflow in the same cycle as a clear still latches.
        if (w_clr_sticky) begin
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end
        if (w_wr_data && w_full && !w_pop) begin
            w_overflow_nxt = 1'b1;
        end
        if (w_rd_data && w_empty) begin
            w_underflow_nxt = 1'b1;
        end

        if (w_wr_thresh) begin
            w_thresh_nxt = i_mmio_wr_data[CW-1:0];
        end
    end

    assign w_status = pack_status(16'(r_level), r_underflow, r_overflow, w_full, w_empty);

    mmio_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_mmio_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rdata)
    );

    always_comb begin
        w_rsp_data = '0;
        unique case (r_s1_sel)
            SelData:   w_rsp_data = r_s1_pop ? w_ram_rdata : '0;
            SelStatus: w_rsp_data = DATA_W'(r_s1_status);
            SelCtrl:   w_rsp_data = '0;
            SelThresh: w_rsp_data = DATA_W'(r_s1_thresh);
            default:   w_rsp_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_thresh      <= CW'(DEPTH - 1);
            r_almost_full <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_tid      <= '0;
            r_s1_sel      <= SelData;
            r_s1_pop      <= 1'b0;
            r_s1_status   <= '0;
            r_s1_thresh   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_tid     <= '0;
            r_rsp_data    <= '0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_level       <= w_level_nxt;
            r_overflow    <= w_overflow_nxt;
            r_underflow   <= w_underflow_nxt;
            r_thresh      <= w_thresh_nxt;
            r_almost_full <= (r_level >= r_thresh);

            r_s1_valid    <= w_rd_hit;
            r_s1_tid      <= i_mmio_tid;
            r_s1_sel      <= w_rd_sel;
            r_s1_pop      <= w_pop;
            r_s1_status   <= w_status;
            r_s1_thresh   <= r_thresh;

            r_rsp_valid   <= r_s1_valid;
            r_rsp_tid     <= r_s1_valid ? r_s1_tid : '0;
            r_rsp_data    <= r_s1_valid ? w_rsp_data : '0;
        end
    end

    assign o_rd_rsp_valid = r_rsp_valid;
    assign o_rd_rsp_tid   = r_rsp_tid;
    assign o_rd_rsp_data  = r_rsp_data;
    assign o_level        = r_level;
    assign o_almost_full  = r_almost_full;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Scoreboard bench for mmio_fifo_ctrl: expected read responses are queued at request
// time and matched (data, tid, exact cycle) as the DUT emits them.
module tb_mmio_fifo_ctrl;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CW     = 7;
    localparam logic [15:0] BASE     = 16'h0020;
    localparam logic [15:0] A_DATA   = 16'h0020;
    localparam logic [15:0] A_STATUS = 16'h0022;
    localparam logic [15:0] A_CTRL   = 16'h0024;
    localparam logic [15:0] A_THRESH = 16'h0026;

    logic              clk = 1'b0;
    logic              rst;
    logic              wv;
    logic              rv;
    logic [15:0]       addr;
    logic [8:0]        tid;
    logic [63:0]       wdata;
    logic              rsp_valid;
    logic [8:0]        rsp_tid;
    logic [63:0]       rsp_data;
    logic [CW-1:0]     level;
    logic              almost_full;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    mmio_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_mmio_wr_valid (wv),
        .i_mmio_rd_valid (rv),
        .i_mmio_addr     (addr),
        .i_mmio_tid      (tid),
        .i_mmio_wr_data  (wdata),
        .o_rd_rsp_valid  (rsp_valid),
        .o_rd_rsp_tid    (rsp_tid),
        .o_rd_rsp_data   (rsp_data),
        .o_level         (level),
        .o_almost_full   (almost_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: match responses in order, flag overdue and unexpected ones.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_rsp: tid=%0d no response, required at cycle %0d (now %0d)",
                     sb_q[0].tid, sb_q[0].cyc, cyc);
            sb_q.delete(0);
        end
        if (rsp_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: tid=%0d data=%h at cycle %0d, required none",
                         rsp_tid, rsp_data, cyc);
            end else begin
                mon_e = sb_q[0];
                sb_q.delete(0);
                if (rsp_tid !== mon_e.tid || rsp_data !== mon_e.data || cyc !== mon_e.cyc) begin
                    bad++;
                    $display("FAIL rsp: got tid=%0d data=%h cyc=%0d, required tid=%0d data=%h cyc=%0d",
                             rsp_tid, rsp_data, cyc, mon_e.tid, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic w, input logic r, input logic [15:0] a,
                         input logic [8:0] t, input logic [63:0] d);
        wv    = w;
        rv    = r;
        addr  = a;
        tid   = t;
        wdata = d;
        @(posedge clk);
        #1;
        wv = 1'b0;
        rv = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        drive(1'b1, 1'b0, a, 9'd0, d);
    endtask

    task automatic rd_exp(input logic [15:0] a, input logic [8:0] t, input logic [63:0] e);
        exp_t x;
        x.tid  = t;
        x.data = e;
        x.cyc  = cyc + 2;
        sb_q.push_back(x);
        drive(1'b0, 1'b1, a, t, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        wv    = 1'b0;
        rv    = 1'b0;
        addr  = '0;
        tid   = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_tid !== 9'd0 || rsp_data !== 64'd0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b tid=%0d data=%h, required 0/0/0",
                     rsp_valid, rsp_tid, rsp_data);
        end
        total++;
        if (level !== 7'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_level: got level=%0d af=%b, required 0/0", level, almost_full);
        end
        rst = 1'b0;
        idle(1);
        rd_exp(A_STATUS, 9'd3, 64'h1);
        rd_exp(A_THRESH, 9'd4, 64'd63);
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) wr(A_DATA, 64'hA1 + 64'(i));
        total++;
        if (level !== 7'd4) begin
            bad++;
            $display("FAIL b2b_level_full: got %0d, required 4", level);
        end
        for (int i = 0; i < 4; i++) rd_exp(A_DATA, 9'(5 + i), 64'hA1 + 64'(i));
        idle(3);
        total++;
        if (level !== 7'd0) begin
            bad++;
            $display("FAIL b2b_level_empty: got %0d, required 0", level);
        end
    endtask

    task automatic test_overflow();
        wr(A_CTRL, 64'd3);
        for (int i = 0; i <= DEPTH; i++) wr(A_DATA, 64'hC0DE_0000_0000_0100 + 64'(i));
        total++;
        if (level !== 7'd64 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL ovf_level: got level=%0d af=%b, required 64/1", level, almost_full);
        end
        rd_exp(A_STATUS, 9'd20, 64'h0040_0006);
        wr(A_CTRL, 64'd2);
        rd_exp(A_STATUS, 9'd21, 64'h0040_0002);
        for (int i = 0; i < DEPTH; i++) begin
            rd_exp(A_DATA, 9'(100 + i), 64'hC0DE_0000_0000_0100 + 64'(i));
        end
        idle(3);
        rd_exp(A_STATUS, 9'd22, 64'h1);
        idle(3);
    endtask

    task automatic test_underflow();
        exp_t x;
        rd_exp(A_DATA, 9'd9, 64'd0);
        rd_exp(A_STATUS, 9'd10, 64'h9);
        wr(A_CTRL, 64'd2);
        x.tid  = 9'd11;
        x.data = 64'd0;
        x.cyc  = cyc + 2;
        sb_q.push_back(x);
        drive(1'b1, 1'b1, A_DATA, 9'd11, 64'hBEEF);
        total++;
        if (level !== 7'd1) begin
            bad++;
            $display("FAIL udf_pushpop_level: got %0d, required 1", level);
        end
        rd_exp(A_STATUS, 9'd12, 64'h0001_0008);
        rd_exp(A_DATA, 9'd13, 64'hBEEF);
        idle(3);
    endtask

    task automatic test_thresh();
        wr(A_CTRL, 64'd3);
        wr(A_THRESH, 64'd3);
        rd_exp(A_THRESH, 9'd14, 64'd3);
        for (int i = 0; i < 3; i++) wr(A_DATA, 64'hD0 + 64'(i));
        total++;
        if (level !== 7'd3 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL thr_same_cycle: got level=%0d af=%b, required 3/0", level, almost_full);
        end
        idle(1);
        total++;
        if (almost_full !== 1'b1) begin
            bad++;
            $display("FAIL thr_af_set: got %b, required 1", almost_full);
        end
        rd_exp(A_CTRL, 9'd15, 64'd0);
        wr(A_CTRL, 64'd1);
        total++;
        if (level !== 7'd0 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL flush_level: got level=%0d af=%b, required 0/1", level, almost_full);
        end
        idle(1);
        total++;
        if (almost_full !== 1'b0) begin
            bad++;
            $display("FAIL flush_af_clear: got %b, required 0", almost_full);
        end
        rd_exp(A_STATUS, 9'd16, 64'h1);
        idle(3);
    endtask

    task automatic test_pop_then_flush();
        wr(A_DATA, 64'h55);
        wr(A_DATA, 64'h66);
        rd_exp(A_DATA, 9'd17, 64'h55);
        wr(A_CTRL, 64'd1);
        idle(3);
        total++;
        if (level !== 7'd0) begin
            bad++;
            $display("FAIL popflush_level: got %0d, required 0", level);
        end
        wr(A_DATA, 64'h99);
        rd_exp(A_DATA, 9'd18, 64'h99);
        idle(3);
    endtask

    task automatic test_reset_midflight();
        wr(A_DATA, 64'h77);
        wr(A_DATA, 64'h78);
        drive(1'b0, 1'b1, A_DATA, 9'd19, 64'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_tid !== 9'd0 || rsp_data !== 64'd0) begin
            bad++;
            $display("FAIL midrst_rsp: got v=%b tid=%0d data=%h, required 0/0/0",
                     rsp_valid, rsp_tid, rsp_data);
        end
        total++;
        if (level !== 7'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL midrst_level: got level=%0d af=%b, required 0/0", level, almost_full);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        rd_exp(A_STATUS, 9'd23, 64'h1);
        idle(3);
    endtask

    task automatic test_no_hit();
        drive(1'b0, 1'b1, 16'h0000, 9'd30, 64'd0);
        drive(1'b1, 1'b0, 16'h0000, 9'd0, 64'h1234);
        drive(1'b0, 1'b1, 16'h0021, 9'd31, 64'd0);
        drive(1'b0, 1'b1, BASE + 16'h0008, 9'd32, 64'd0);
        drive(1'b1, 1'b0, BASE + 16'h0001, 9'd0, 64'h5678);
        idle(4);
        total++;
        if (level !== 7'd0) begin
            bad++;
            $display("FAIL nohit_level: got %0d, required 0", level);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_thresh();
        test_pop_then_flush();
        test_reset_midflight();
        test_no_hit();
        idle(2);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL outstanding: got %0d queued responses, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
